// File: rtl/mdu_sequencer.sv
// rtl/mdu_sequencer.sv - iterative RV32M multiply/divide controller driving a shared ALU
module mdu_sequencer #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [2:0]               in_funct3,
    input  logic [DATA_WIDTH-1:0]    in_a,
    input  logic [DATA_WIDTH-1:0]    in_b,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    out_result,
    output logic                     busy,
    input  logic                     flush,
    output logic [DATA_WIDTH-1:0]    alu_a,
    output logic [DATA_WIDTH-1:0]    alu_b,
    output logic [OPCODE_LENGTH-1:0] alu_op,
    input  logic [DATA_WIDTH-1:0]    alu_result
);

    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [OPCODE_LENGTH-1:0] OP_ADD  = OPCODE_LENGTH'(4'b0010);
    localparam logic [OPCODE_LENGTH-1:0] OP_SUB  = OPCODE_LENGTH'(4'b0011);
    localparam logic [DATA_WIDTH-1:0]    MIN_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIX, S_DONE} state_t;

    state_t state, state_nxt;

    logic                  is_mul, is_rem, q_neg, r_neg;
    logic [DATA_WIDTH-1:0] acc, opa, opb, res;
    logic [CW-1:0]         cnt;

    logic                  dec_div, dec_signed, dec_rem, a_neg, b_neg;
    logic                  div_zero, div_ovf, accept, div_ge, fix_neg;
    logic [DATA_WIDTH-1:0] a_mag, b_mag, bypass_val, r_shift, fix_val;

    // opa holds the multiplicand or dividend; quotient bits shift into its LSB as the dividend leaves
    always_comb begin
        dec_div    = in_funct3[2];
        dec_signed = dec_div & ~in_funct3[0];
        dec_rem    = dec_div & in_funct3[1];
        a_neg      = dec_signed & in_a[DATA_WIDTH-1];
        b_neg      = dec_signed & in_b[DATA_WIDTH-1];
        a_mag      = a_neg ? -in_a : in_a;
        b_mag      = b_neg ? -in_b : in_b;
        div_zero   = dec_div & (in_b == '0);
        div_ovf    = dec_signed & (in_a == MIN_NEG) & (in_b == '1);
        bypass_val = div_zero ? (dec_rem ? in_a : '1) : (dec_rem ? '0 : MIN_NEG);
        accept     = (state == S_IDLE) & in_valid & ~flush;
        r_shift    = {acc[DATA_WIDTH-2:0], opa[DATA_WIDTH-1]};
        // a set remainder MSB means the shifted value overflowed W bits, so it exceeds any divisor
        div_ge     = acc[DATA_WIDTH-1] | (r_shift >= opb);
        fix_val    = (is_mul | is_rem) ? acc : opa;
        fix_neg    = is_rem ? r_neg : q_neg;
    end

    always_comb begin
        state_nxt = state;
        alu_a     = '0;
        alu_b     = '0;
        alu_op    = OP_ADD;
        case (state)
            S_IDLE: begin
                if (accept) state_nxt = (div_zero | div_ovf) ? S_DONE : S_ITER;
            end
            S_ITER: begin
                if (is_mul) begin
                    alu_a = acc;
                    alu_b = opa;
                end else begin
                    alu_op = OP_SUB;
                    alu_a  = r_shift;
                    alu_b  = opb;
                end
                if (cnt == '0) state_nxt = S_FIX;
            end
            S_FIX: begin
                if (fix_neg) begin
                    alu_op = OP_SUB;
                    alu_b  = fix_val;
                end else begin
                    alu_a = fix_val;
                end
                state_nxt = S_DONE;
            end
            S_DONE: begin
                if (out_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        if (flush) state_nxt = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            is_mul <= 1'b0;
            is_rem <= 1'b0;
            q_neg  <= 1'b0;
            r_neg  <= 1'b0;
            acc    <= '0;
            opa    <= '0;
            opb    <= '0;
            res    <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        is_mul <= ~dec_div;
                        is_rem <= dec_rem;
                        q_neg  <= a_neg ^ b_neg;
                        r_neg  <= a_neg;
                        acc    <= '0;
                        opa    <= a_mag;
                        opb    <= b_mag;
                        cnt    <= CW'(DATA_WIDTH - 1);
                        if (div_zero | div_ovf) res <= bypass_val;
                    end
                end
                S_ITER: begin
                    cnt <= cnt - CW'(1);
                    if (is_mul) begin
                        if (opb[0]) acc <= alu_result;
                        opa <= opa << 1;
                        opb <= opb >> 1;
                    end else begin
                        acc <= div_ge ? alu_result : r_shift;
                        opa <= {opa[DATA_WIDTH-2:0], div_ge};
                    end
                end
                S_FIX: begin
                    if (!flush) res <= alu_result;
                end
                default: ;
            endcase
        end
    end

    assign in_ready   = (state == S_IDLE);
    assign busy       = (state != S_IDLE);
    assign out_valid  = (state == S_DONE);
    assign out_result = res;

endmodule

// File: doc/mdu_sequencer.md
Name: mdu_sequencer

Overview:
- Multi-cycle RV32M multiply/divide controller.
- Computes MUL/DIV/DIVU/REM/REMU iteratively, issuing one ADD or SUB per cycle to the shared combinational ALU via its SrcA/SrcB/Operation/ALUResult interface.
- Sits beside the EX stage; the pipeline stalls while it is busy.
- Valid/ready handshake on both input and output.

Parameters:
- DATA_WIDTH, 32, operand/result width; iteration count equals DATA_WIDTH.
- OPCODE_LENGTH, 4, width of the ALU operation code.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  request present.
- in_ready  out  1  sequencer can accept; high only in IDLE.
- in_funct3  in  3  000 MUL, 100 DIV, 101 DIVU, 110 REM, 111 REMU. Other codes are treated as MUL.
- in_a  in  DATA_WIDTH  rs1 (multiplicand / dividend).
- in_b  in  DATA_WIDTH  rs2 (multiplier / divisor).
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes result.
- out_result  out  DATA_WIDTH  result; stable while out_valid is high.
- busy  out  1  high in any state other than IDLE.
- flush  in  1  synchronous abort.
- alu_a  out  DATA_WIDTH  drives ALU SrcA.
- alu_b  out  DATA_WIDTH  drives ALU SrcB.
- alu_op  out  OPCODE_LENGTH  drives ALU Operation: 4'b0010 ADD, 4'b0011 SUB.
- alu_result  in  DATA_WIDTH  ALU ALUResult; combinational, consumed in the same cycle.

Behaviour:
- Reset (rst_n low, async):
  - State goes to IDLE.
  - in_ready=1, out_valid=0, busy=0, out_result=0.
  - alu_a=0, alu_b=0, alu_op=4'b0010.
  - All internal registers cleared.
- States: IDLE, ITER, FIX, DONE.
- IDLE:
  - Acceptance occurs on a rising edge with in_valid & in_ready.
  - At acceptance, latch op, sign mode and the operands.
  - For signed DIV/REM, latch |a| and |b| and record the quotient sign (a_sign^b_sign) and remainder sign (a_sign).
  - Iteration counter is loaded with DATA_WIDTH-1.
- Bypass cases, decided at acceptance:
  - Divide by zero (b==0): quotient = all ones, remainder = a.
  - Signed overflow (a==0x80000000, b==0xFFFFFFFF): quotient = 0x80000000, remainder = 0.
  - Both cases go IDLE->DONE directly, so out_valid is high 1 cycle after acceptance.
- ITER (DATA_WIDTH cycles, one ALU op per cycle):
  - MUL: alu_op=ADD, alu_a=acc, alu_b=mcand. If the multiplier LSB is 1, acc<=alu_result; otherwise acc is held. Then mcand<<=1 and multiplier>>=1. Low DATA_WIDTH bits only.
  - DIV*: shifted remainder r'={rem[W-2:0], dividend MSB}; alu_op=SUB, alu_a=r', alu_b=divisor.
    - If r' >= divisor (unsigned compare, internal): rem<=alu_result and shift 1 into the quotient.
    - Otherwise: rem<=r' and shift 0 into the quotient.
    - Dividend shifts left by 1 each cycle.
  - When the counter reaches 0, go to FIX.
- FIX (1 cycle):
  - Where the sign requires it, negate the selected result via ALU SUB with alu_a=0, alu_b=value.
  - Latch out_result, then go to DONE.
  - Unsigned ops and MUL still spend this cycle; alu_op=ADD, alu_b=0.
- Latency: out_valid rises DATA_WIDTH+2 cycles after acceptance (34 for W=32).
- DONE:
  - out_valid=1.
  - Leave for IDLE on a rising edge with out_ready=1.
  - out_result holds its value until then.
  - in_ready rises the cycle after the handshake; there is no same-cycle accept.
- Outside ITER/FIX: alu_op=ADD, alu_a=0, alu_b=0, so the shared ALU is free for the pipeline.
- flush:
  - In any state, the next state is IDLE, out_valid drops, and no result is produced.
  - flush beats in_valid in IDLE, so a request presented together with flush is not accepted.
  - flush beats out_ready in DONE.
- Reset mid-operation: immediate return to reset values; the in-flight operation is lost.
- No new request is accepted while busy. in_a/in_b may change after acceptance without effect.

Test Plan:
- MUL 7*6: accept, then out_valid at exactly cycle 34 with out_result=42. alu_op is ADD throughout ITER.
- DIV -7/2 → out_result=0xFFFFFFFD (-3); REM -7/2 → 0xFFFFFFFF (-1); DIVU 100/7 → 14; REMU 100/7 → 2. Each at 34 cycles.
- DIVU 5/0 → 0xFFFFFFFF and REM 5/0 → 5, with out_valid 1 cycle after accept; DIV 0x80000000/0xFFFFFFFF → 0x80000000 with 1-cycle latency.
- Backpressure: hold out_ready=0 for 10 cycles after a MUL 0xFFFFFFFF*0xFFFFFFFF. out_result stays 0x00000001 and busy stays 1; release out_ready and in_ready rises the next cycle.
- flush at ITER cycle 10 of a DIVU → IDLE next cycle, no out_valid, alu_op/alu_a/alu_b return to ADD/0/0; a following MUL 3*3 → 9.
- Deassert rst_n mid-ITER, asynchronously between clock edges → all outputs at reset values without waiting for a clock edge; after release, DIVU 9/3 → 3.
